user_input_conditioner: RTL and testbench

Multi-channel conditioner for asynchronous user inputs such as push-buttons and switches. Each channel is synchronised, debounced and edge-detected, and emits a one-clock-cycle pulse per qualified press or release. This is the generalised successor of the single-channel button-to-pulse converter. It feeds FFT-trigger, mode-select and display-control logic in the visualizer.

---
 rtl/user_input_conditioner.sv | 94 +++++++++
 tb/tb_user_input_conditioner.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/user_input_conditioner.sv
// user_input_conditioner: per-channel synchronise, debounce and edge-to-pulse conditioning of raw user inputs.
// Ports:
//   CLK   - system clock
//   RST   - synchronous active-high reset
//   IN    - raw asynchronous inputs, one bit per channel
//   MODE  - shared edge select: 00 rising, 01 falling, 10 both, 11 none
//   EN    - output enable; debouncing continues while low
//   LEVEL - debounced registered level per channel
//   OUT   - one-cycle pulse per qualified debounced edge
// Optional: define USER_INPUT_REPEAT_EN to add auto-repeat pulses while the active level is held.
module user_input_conditioner #(
    parameter int N_CH            = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 1024,
    parameter int REPEAT_PERIOD   = 256
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N_CH-1:0] IN,
    input  logic [1:0]      MODE,
    input  logic            EN,
    output logic [N_CH-1:0] LEVEL,
    output logic [N_CH-1:0] OUT
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    typedef enum logic [1:0] {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO} state_t;
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        state_t                 state_q, state_d;
        logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
        logic                   level_q, level_d, out_q, out_d;
        logic                   hi_side, want, hit, qual, fire;
        // Counter is always 0 in the stable states, so STABLE_x and CHK_x share one increment path.
        always_comb begin
            sync_d  = {sync_q[SYNC_STAGES-2:0], IN[c]};
            hi_side = (state_q == STABLE_LO) || (state_q == CHK_HI);
            want    = hi_side ? sync_q[SYNC_STAGES-1] : ~sync_q[SYNC_STAGES-1];
            cnt_inc = cnt_q + CW'(1);
            hit     = want && (cnt_inc == CW'(DEBOUNCE_CYCLES));
            state_d = !want ? (hi_side ? STABLE_LO : STABLE_HI)
                    : hit   ? (hi_side ? STABLE_HI : STABLE_LO)
                    :         (hi_side ? CHK_HI : CHK_LO);
            cnt_d   = (want && !hit) ? cnt_inc : '0;
            level_d = hit ? hi_side : level_q;
            qual    = EN && ((level_d && !level_q && (MODE == 2'b00 || MODE == 2'b10))
                          || (!level_d && level_q && (MODE == 2'b01 || MODE == 2'b10)));
        end
`ifdef USER_INPUT_REPEAT_EN
        localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
        logic [RW-1:0] rcnt_q, rcnt_d, rcnt_inc;
        logic          rep_q, rep_d, active;
        // Active level is 1 for MODE 00/10 and 0 for MODE 01; any level change restarts the timing.
        always_comb begin
            active   = EN && (MODE != 2'b11) && (level_q == (MODE != 2'b01)) && (level_d == level_q);
            rcnt_inc = rcnt_q + RW'(1);
            fire     = active && (rcnt_inc == (rep_q ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY)));
            rcnt_d   = (active && !fire) ? rcnt_inc : '0;
            rep_d    = active && (rep_q || fire);
        end
        always_ff @(posedge CLK) begin
            if (RST) begin
                rcnt_q <= '0;
                rep_q  <= 1'b0;
            end else begin
                rcnt_q <= rcnt_d;
                rep_q  <= rep_d;
            end
        end
`else
        logic unused_repeat;
        assign unused_repeat = ^{REPEAT_DELAY, REPEAT_PERIOD};
        assign fire = 1'b0;
`endif
        assign out_d = qual | fire;
        always_ff @(posedge CLK) begin
            if (RST) begin
                sync_q  <= '0;
                state_q <= STABLE_LO;
                cnt_q   <= '0;
                level_q <= 1'b0;
                out_q   <= 1'b0;
            end else begin
                sync_q  <= sync_d;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                out_q   <= out_d;
            end
        end
        assign LEVEL[c] = level_q;
        assign OUT[c]   = out_q;
    end
endmodule

// File: tb/tb_user_input_conditioner.sv
// tb_user_input_conditioner: directed self-checking bench for user_input_conditioner.
module tb_user_input_conditioner;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [3:0] in_r = 4'b0000;
    logic [3:0] level, out;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    user_input_conditioner dut (
        .CLK(clk), .RST(rst), .IN(in_r), .MODE(mode), .EN(en), .LEVEL(level), .OUT(out)
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // OUT must stay 0 for n-1 edges and equal m on edge n.
    task automatic pulse_at(input string tag, input int n, input logic [3:0] m);
        for (int i = 1; i <= n; i++) begin
            tick();
            check(tag, out, (i == n) ? m : 4'b0000);
        end
    endtask

    initial begin
        tick();
        tick();
        check("rst_level", level, 4'b0000);
        check("rst_out", out, 4'b0000);
        rst = 1'b0;
        in_r = 4'b0001;
        pulse_at("t1_pulse", 18, 4'b0001);
        check("t1_level", level, 4'b0001);
        pulse_at("t1_after", 3, 4'b0000);

        in_r = 4'b0011;
        pulse_at("t2_bounce_hi", 5, 4'b0000);
        in_r = 4'b0001;
        pulse_at("t2_bounce_lo", 3, 4'b0000);
        in_r = 4'b0011;
        pulse_at("t2_press", 18, 4'b0010);
        check("t2_level", level, 4'b0011);
        mode = 2'b01;
        in_r = 4'b0001;
        pulse_at("t2_release", 18, 4'b0010);
        check("t2_rel_level", level, 4'b0001);
        in_r = 4'b0011;
        pulse_at("t2_press_m01", 18, 4'b0000);
        check("t2_m01_level", level, 4'b0011);
        mode = 2'b00;
        in_r = 4'b0001;
        pulse_at("t2_rel_m00", 18, 4'b0000);

        mode = 2'b10;
        in_r = 4'b0101;
        pulse_at("t3_both_rise", 18, 4'b0100);
        in_r = 4'b0001;
        pulse_at("t3_both_fall", 18, 4'b0100);
        mode = 2'b11;
        in_r = 4'b0101;
        pulse_at("t3_none_rise", 18, 4'b0000);
        check("t3_none_level", level, 4'b0101);
        in_r = 4'b0001;
        pulse_at("t3_none_fall", 18, 4'b0000);
        check("t3_none_lvl2", level, 4'b0001);

        mode = 2'b00;
        in_r = 4'b0101;
        pulse_at("t4_count", 12, 4'b0000);
        rst = 1'b1;
        tick();
        check("t4_rst_level", level, 4'b0000);
        check("t4_rst_out", out, 4'b0000);
        rst = 1'b0;
        pulse_at("t4_after_rst", 18, 4'b0101);
        check("t4_level", level, 4'b0101);

        en = 1'b0;
        in_r = 4'b1101;
        pulse_at("t5_en_off", 18, 4'b0000);
        check("t5_en_level", level, 4'b1101);
        en = 1'b1;
        in_r = 4'b0000;
        pulse_at("t5_fall_m00", 18, 4'b0000);
        check("t5_all_low", level, 4'b0000);
        in_r = 4'b1111;
        pulse_at("t5_all_press", 18, 4'b1111);
        mode = 2'b01;
        in_r = 4'b0000;
        pulse_at("t5_all_rel", 18, 4'b1111);

        mode = 2'b10;
        for (int k = 0; k < 3; k++) begin
            in_r = 4'b0001;
            pulse_at("t5_glitch_hi", 15, 4'b0000);
            in_r = 4'b0000;
            pulse_at("t5_glitch_lo", 15, 4'b0000);
        end
        check("t5_glitch_lvl", level, 4'b0000);
        in_r = 4'b0001;
        pulse_at("t5_exact_hi", 16, 4'b0000);
        in_r = 4'b0000;
        pulse_at("t5_exact_rise", 2, 4'b0001);
        check("t5_exact_lvl", level, 4'b0001);
        pulse_at("t5_exact_fall", 16, 4'b0001);
        check("t5_exact_lvl0", level, 4'b0000);

`ifdef USER_INPUT_REPEAT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mode = 2'b00;
        in_r = 4'b1000;
        pulse_at("t6_first", 18, 4'b1000);
        pulse_at("t6_delay", 1024, 4'b1000);
        pulse_at("t6_period1", 256, 4'b1000);
        pulse_at("t6_period2", 256, 4'b1000);
        in_r = 4'b0000;
        pulse_at("t6_release", 300, 4'b0000);
        check("t6_level", level, 4'b0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
